// File: rtl/aes_round_ctrl.sv
// ============================================================================
// aes_round_ctrl
// ----------------------------------------------------------------------------
// Sequencer for an iterative AES-128 encryption round datapath. Owns the
// 128-bit cipher state register and the round counter. It accepts one
// plaintext block per handshake and performs the initial AddRoundKey itself.
// It then steps the external round datapath NR times, requesting each round
// key from the key schedule, and finally presents the ciphertext.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous reset, active HIGH despite the name
//   in_valid   : plaintext block offered        in_ready : block can be taken
//   in_block   : plaintext block
//   rk_req     : round-key request (held until rk_valid)
//   rk_idx     : index of the requested round key, 0..NR
//   rk_valid   : rk carries round key rk_idx this cycle
//   rk         : round key
//   dp_state   : state register to round datapath
//   dp_key     : round key to datapath (pass-through of rk)
//   dp_round   : current round 1..NR, 0 outside ROUND
//   dp_final   : last round marker (datapath bypasses mixColumn)
//   dp_result  : combinational round result from datapath
//   out_valid  : ciphertext available           out_ready : consumer accepts
//   out_block  : ciphertext (state register)
//   busy       : controller is not idle
// ============================================================================
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_block,
   output logic          rk_req,
   output logic [RW-1:0] rk_idx,
   input  logic          rk_valid,
   input  logic [127:0]  rk,
   output logic [127:0]  dp_state,
   output logic [127:0]  dp_key,
   output logic [RW-1:0] dp_round,
   output logic          dp_final,
   input  logic [127:0]  dp_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_block,
   output logic          busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEY0  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } fsm_t;

   localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

   fsm_t          fsm_r;
   fsm_t          fsm_nxt_s;
   logic [127:0]  state_r;
   logic [RW-1:0] round_r;
   logic          last_round_s;

   assign last_round_s = (round_r == LAST_ROUND);

   // FSM state register
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         fsm_r <= IDLE;
      end else begin
         fsm_r <= fsm_nxt_s;
      end
   end

   // Next-state decode; every state waits on its own handshake and holds otherwise
   always_comb begin
      fsm_nxt_s = fsm_r;
      case (fsm_r)
         IDLE: begin
            if (in_valid) fsm_nxt_s = KEY0;
            else          fsm_nxt_s = IDLE;
         end
         KEY0: begin
            if (rk_valid) fsm_nxt_s = ROUND;
            else          fsm_nxt_s = KEY0;
         end
         ROUND: begin
            if (rk_valid && last_round_s) fsm_nxt_s = DONE;
            else                          fsm_nxt_s = ROUND;
         end
         DONE: begin
            // in_ready stays low here, so the next block is taken one cycle later in IDLE
            if (out_ready) fsm_nxt_s = IDLE;
            else           fsm_nxt_s = DONE;
         end
         default: fsm_nxt_s = IDLE;
      endcase
   end

   // Cipher state and round counter; they only advance on an accepted key
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r <= 128'h0;
         round_r <= '0;
      end else begin
         case (fsm_r)
            IDLE: begin
               if (in_valid) state_r <= in_block;
            end
            KEY0: begin
               if (rk_valid) begin
                  state_r <= state_r ^ rk;
                  round_r <= RW'(1);
               end
            end
            ROUND: begin
               if (rk_valid) begin
                  state_r <= dp_result;
                  if (last_round_s) round_r <= '0;
                  else              round_r <= round_r + RW'(1);
               end
            end
            default: begin
               state_r <= state_r;
               round_r <= round_r;
            end
         endcase
      end
   end

   // Output decode from the registered FSM state
   always_comb begin
      in_ready  = 1'b0;
      rk_req    = 1'b0;
      rk_idx    = '0;
      dp_round  = '0;
      dp_final  = 1'b0;
      out_valid = 1'b0;
      case (fsm_r)
         IDLE: begin
            in_ready = 1'b1;
         end
         KEY0: begin
            rk_req = 1'b1;
            rk_idx = '0;
         end
         ROUND: begin
            rk_req   = 1'b1;
            rk_idx   = round_r;
            dp_round = round_r;
            dp_final = last_round_s;
         end
         DONE: begin
            out_valid = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   assign busy      = (fsm_r != IDLE);
   assign dp_state  = state_r;
   assign out_block = state_r;
   assign dp_key    = rk;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ============================================================================
// tb_aes_round_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for aes_round_ctrl. Provides a behavioural AES-128
// round datapath and key schedule (key 000102..0f), or a stub XOR datapath.
// Expected ciphertexts go into a queue at block acceptance and are compared
// when the DUT completes its output handshake.
// ============================================================================
module tb_aes_round_ctrl;
   localparam int NR = 10;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  in_block;
   logic          rk_req;
   logic [RW-1:0] rk_idx;
   logic          rk_valid;
   logic [127:0]  rk;
   logic [127:0]  dp_state;
   logic [127:0]  dp_key;
   logic [RW-1:0] dp_round;
   logic          dp_final;
   logic [127:0]  dp_result;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  out_block;
   logic          busy;

   always #5 clk = ~clk;

   aes_round_ctrl #(.NR(NR), .RW(RW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
      .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk(rk),
      .dp_state(dp_state), .dp_key(dp_key), .dp_round(dp_round),
      .dp_final(dp_final), .dp_result(dp_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
      .busy(busy)
   );

   int           checks   = 0;
   int           failures = 0;
   logic [127:0] exp_q[$];
   logic [7:0]   sbox_t [256];
   logic [127:0] rkeys [NR+1];
   bit           stub_mode;

   localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] calc_sbox(input logic [7:0] a);
      logic [7:0] inv;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input bit last);
      logic [127:0] u;
      logic [127:0] t;
      logic [7:0]   a0, a1, a2, a3;
      u = 128'h0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            u[127-8*(r+4*c) -: 8] = sbox_t[gb(s, r + 4*((c+r)%4))];
      t = u;
      if (!last) begin
         for (int c = 0; c < 4; c++) begin
            a0 = gb(u, 4*c); a1 = gb(u, 4*c+1); a2 = gb(u, 4*c+2); a3 = gb(u, 4*c+3);
            t[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            t[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            t[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            t[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
         end
      end
      return t ^ k;
   endfunction

   function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ rkeys[0];
      for (int r = 1; r <= NR; r++) s = aes_round(s, rkeys[r], r == NR);
      return s;
   endfunction

   // Datapath and key schedule models driven from the DUT's requests
   always_comb begin
      if (stub_mode) begin
         dp_result = dp_state ^ dp_key;
         rk        = {124'h0, rk_idx};
      end else begin
         dp_result = aes_round(dp_state, dp_key, dp_final);
         rk        = (int'(rk_idx) <= NR) ? rkeys[rk_idx] : 128'h0;
      end
   end

   // Scoreboard: compare ciphertext at each completed output handshake
   always @(negedge clk) begin
      if (!rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got %h expected no output", out_block);
         end else begin
            chk("ciphertext", out_block, exp_q.pop_front());
         end
      end
   end

   // Run one block through the controller.
   //   mask  : bit n low-drives rk_valid in cycle n after acceptance
   //   hold  : cycles out_ready stays low in DONE
   //   abort : round at which reset is pulsed (0 = none)
   //   b2b   : offer next_pt during the DONE handshake cycle
   task automatic run_block(input logic [127:0] pt, input logic [127:0] ct,
                            input logic [63:0] mask, input int hold, input int lat,
                            input int abort, input bit b2b, input logic [127:0] next_pt);
      int cnt;
      int exp_idx;
      int finals;
      bit done;
      out_ready = (hold == 0);
      in_block  = pt;
      in_valid  = 1'b1;
      chk("in_ready_at_offer", in_ready, 1'b1);
      exp_q.push_back(ct);
      tick();
      in_valid = 1'b0;
      in_block = ~pt;
      cnt = 1; exp_idx = 0; finals = 0; done = 1'b0;
      while (!done && cnt < 60) begin
         if (out_valid) begin
            done     = 1'b1;
            rk_valid = 1'b1;
         end else begin
            rk_valid = !mask[cnt];
            if (cnt == 1) chk("captured_block", dp_state, pt);
            chk("rk_req", rk_req, 1'b1);
            chk("rk_idx", rk_idx, exp_idx);
            chk("dp_round", dp_round, exp_idx);
            chk("dp_final", dp_final, exp_idx == NR);
            chk("in_ready_busy", in_ready, 1'b0);
            if (dp_final) finals++;
            if (abort != 0 && exp_idx == abort) begin
               #2 rst_n = 1'b1;
               #1;
               chk("abort_busy", busy, 1'b0);
               chk("abort_in_ready", in_ready, 1'b1);
               chk("abort_state", dp_state, 128'h0);
               chk("abort_out_valid", out_valid, 1'b0);
               chk("abort_rk_req", rk_req, 1'b0);
               void'(exp_q.pop_back());
               tick();
               rst_n = 1'b0;
               for (int i = 0; i < 3; i++) begin
                  chk("post_abort_no_output", out_valid, 1'b0);
                  chk("post_abort_idle", busy, 1'b0);
                  tick();
               end
               return;
            end
            tick();
            if (rk_valid) exp_idx++;
            cnt++;
         end
      end
      chk("done_in_budget", done, 1'b1);
      chk("latency", cnt, lat);
      if (mask == 64'h0) chk("final_once", finals, 1);
      for (int h = 0; h < hold; h++) begin
         in_valid = h[0];
         chk("hold_out_valid", out_valid, 1'b1);
         chk("hold_out_block", out_block, ct);
         chk("hold_in_ready", in_ready, 1'b0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      if (b2b) begin
         in_block = next_pt;
         in_valid = 1'b1;
      end
      tick();
      chk("idle_busy", busy, 1'b0);
      chk("idle_in_ready", in_ready, 1'b1);
      chk("idle_out_valid", out_valid, 1'b0);
      chk("idle_state_kept", out_block, ct);
   endtask

   typedef struct {
      logic [127:0] pt;
      logic [127:0] ct;
      logic [63:0]  mask;
      int           hold;
      int           lat;
      bit           stub;
   } vec_t;

   vec_t vecs[4];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0]  w [44];
      logic [31:0]  tmp;
      logic [7:0]   rc;
      logic [127:0] key;
      logic [127:0] pa, pb;
      int a, b;

      stub_mode = 1'b1;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_block  = 128'h0;
      rk_valid  = 1'b0;
      out_ready = 1'b0;

      for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(i[7:0]);
      key = 128'h000102030405060708090a0b0c0d0e0f;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                  ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r <= NR; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      stub_mode = 1'b0;

      chk("ref_model_kat", ref_encrypt(PT1), CT1);

      // Reset state
      tick(); tick();
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_rk_req", rk_req, 1'b0);
      chk("rst_rk_idx", rk_idx, 0);
      chk("rst_dp_state", dp_state, 128'h0);
      chk("rst_out_block", out_block, 128'h0);
      chk("rst_dp_round", dp_round, 0);
      chk("rst_dp_final", dp_final, 1'b0);
      rst_n = 1'b0;
      tick();

      a = $urandom_range(2, 11);
      b = a;
      while (b == a) b = $urandom_range(2, 11);
      pa = {$urandom, $urandom, $urandom, $urandom};

      vecs[0] = '{pt: PT1, ct: CT1, mask: 64'h0, hold: 0, lat: 12, stub: 1'b0};
      vecs[1] = '{pt: PT1, ct: CT1,
                  mask: (64'd1 << 1) | (64'd1 << a) | (64'd1 << b),
                  hold: 0, lat: 15, stub: 1'b0};
      vecs[2] = '{pt: 128'h0, ct: 128'h0b, mask: 64'h0, hold: 0, lat: 12, stub: 1'b1};
      vecs[3] = '{pt: pa, ct: ref_encrypt(pa), mask: 64'h0, hold: 5, lat: 12, stub: 1'b0};

      for (int v = 0; v < 4; v++) begin
         stub_mode = vecs[v].stub;
         run_block(vecs[v].pt, vecs[v].ct, vecs[v].mask, vecs[v].hold, vecs[v].lat,
                   0, 1'b0, 128'h0);
         stub_mode = 1'b0;
      end

      // Back-to-back: second block offered during the DONE handshake
      pa = {$urandom, $urandom, $urandom, $urandom};
      pb = {$urandom, $urandom, $urandom, $urandom};
      run_block(pa, ref_encrypt(pa), 64'h0, 0, 12, 0, 1'b1, pb);
      run_block(pb, ref_encrypt(pb), 64'h0, 0, 12, 0, 1'b0, 128'h0);

      // Reset pulse during round 5, then a full block
      run_block(PT1, CT1, 64'h0, 0, 12, 5, 1'b0, 128'h0);
      run_block(PT1, CT1, 64'h0, 0, 12, 0, 1'b0, 128'h0);

      tick();
      chk("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
